// File: rtl/dmem_arbiter_pkg.sv
// Shared pipeline-buffer definitions: data-memory arbiter state encoding and the
// fixed access size used for debug transfers.
package Pipe_Buf_Reg_PKG;

  typedef enum logic [1:0] {
    S_ARB   = 2'd0,
    S_LOCK  = 2'd1,
    S_YIELD = 2'd2
  } arb_state_e;

  // Debug transfers are always full words.
  localparam logic [2:0] DBG_FUNCT3 = 3'b010;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: pipeline MEM stage has priority, debug master is
// protected by a starvation counter and may take bounded locked bursts.
module dmem_arbiter
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic                  cpu_stall,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic                  dbg_lock,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned CNT_W = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(STARVE_MAX - 1);

  arb_state_e       state_q, state_d;
  logic             cpu_act;
  logic             gnt_raw;
  logic             starve_inc, starve_clr, starve_full;
  logic             lock_inc, lock_clr, lock_full;
  logic [CNT_W-1:0] starve_cnt, lock_cnt;
  logic [1:0]       rd_owner_q;  // {valid, debug}

  assign cpu_act = cpu_rd | cpu_wr;

  always_comb begin
    gnt_raw = 1'b0;
    state_d = state_q;
    unique case (state_q)
      S_ARB: begin
        gnt_raw = dbg_req & (~cpu_act | starve_full);
        // With a one-grant burst limit the entry grant already exhausts it.
        if (gnt_raw && dbg_lock) state_d = (STARVE_MAX == 1) ? S_YIELD : S_LOCK;
      end
      S_LOCK: begin
        gnt_raw = dbg_req & dbg_lock;
        if (!gnt_raw) begin
          state_d = S_ARB;
        end else if (lock_cnt == LOCK_LAST) begin
          state_d = S_YIELD;
        end
      end
      S_YIELD: state_d = S_ARB;
      default: state_d = S_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_gnt   = gnt_raw & ~reset;
  assign cpu_stall = cpu_act & dbg_gnt;

  assign starve_inc = dbg_req & ~dbg_gnt;
  assign starve_clr = ~dbg_req | dbg_gnt;

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .count  (starve_cnt),
    .at_max (starve_full)
  );

  // Entering the burst from S_ARB counts the first grant; leaving it rearms.
  assign lock_inc = dbg_gnt & dbg_lock & (state_q != S_YIELD);
  assign lock_clr = (state_d != S_LOCK);

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (STARVE_MAX)
  ) u_lock_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (lock_inc),
    .clr    (lock_clr),
    .count  (lock_cnt),
    .at_max (lock_full)
  );

  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_funct3 = cpu_funct3;
    if (dbg_gnt) begin
      mem_rd     = ~dbg_we;
      mem_wr     = dbg_we;
      mem_addr   = dbg_addr;
      mem_wdata  = dbg_wdata;
      mem_funct3 = DBG_FUNCT3;
    end else if (!reset) begin
      mem_rd = cpu_rd;
      mem_wr = cpu_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q <= 2'b00;
    end else begin
      rd_owner_q <= {mem_rd, mem_rd & dbg_gnt};
    end
  end

  assign dbg_rvalid = rd_owner_q[1] & rd_owner_q[0] & ~reset;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory behind it.
module tb_dmem_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0]    cpu_funct3;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DM_ADDRESS (AW),
    .DATA_W     (DW),
    .STARVE_MAX (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_funct3 (cpu_funct3),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_lock   (dbg_lock),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata)
  );

  // Word memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = 3'b001;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    // Reset cycle: activity on both sides must be suppressed.
    cpu_rd = 1; dbg_req = 1;
    #1;
    @(negedge clk);
    check("rst_gnt", dbg_gnt, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_rvalid", dbg_rvalid, 0);
    check("rst_rdata", dbg_rdata, 0);
    cyc();
    reset = 0;
    idle_inputs();

    // CPU passthrough
    cpu_wr = 1; cpu_addr = 9'h020; cpu_wdata = 32'h1234_5678; cpu_funct3 = 3'b001;
    @(negedge clk);
    check("pass_gnt", dbg_gnt, 0);
    check("pass_wr", mem_wr, 1);
    check("pass_addr", mem_addr, 9'h020);
    check("pass_f3", mem_funct3, 3'b001);
    check("pass_wdata", mem_wdata, 32'h1234_5678);
    cyc();
    idle_inputs();

    // Idle CPU: debug write then debug read of 0x010
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h010; dbg_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("dw_gnt", dbg_gnt, 1);
    check("dw_wr", mem_wr, 1);
    check("dw_f3", mem_funct3, 3'b010);
    cyc();
    dbg_we = 0;
    @(negedge clk);
    check("dr_gnt", dbg_gnt, 1);
    check("dr_stall", cpu_stall, 0);
    check("dr_rd", mem_rd, 1);
    cyc();
    dbg_req = 0;
    @(negedge clk);
    check("dr_rvalid", dbg_rvalid, 1);
    check("dr_rdata", dbg_rdata, 32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    check("dr_rvalid_off", dbg_rvalid, 0);
    check("dr_rdata_zero", dbg_rdata, 0);
    cyc();

    // Starvation: grant on the 9th cycle only
    cpu_rd = 1; cpu_addr = 9'h030; dbg_req = 1; dbg_we = 0; dbg_addr = 9'h010;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check($sformatf("starve_gnt_%0d", i), dbg_gnt, (i == 9) ? 1 : 0);
      check($sformatf("starve_stall_%0d", i), cpu_stall, (i == 9) ? 1 : 0);
      if (i == 2) check("starve_cpu_rvalid", dbg_rvalid, 0);
      if (i == 9) check("starve_addr", mem_addr, 9'h010);
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    check("starve_rvalid", dbg_rvalid, 1);
    check("starve_rdata", dbg_rdata, 32'hDEAD_BEEF);
    cyc();

    // Locked write burst: 8 grants, 1 yield, resume
    dbg_req = 1; dbg_we = 1; dbg_lock = 1;
    for (int i = 0; i < 10; i++) begin
      dbg_addr = AW'(9'h100 + i);
      dbg_wdata = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      check($sformatf("lock_gnt_%0d", i), dbg_gnt, (i == 8) ? 0 : 1);
      check($sformatf("lock_wr_%0d", i), mem_wr, (i == 8) ? 0 : 1);
      cyc();
    end
    idle_inputs();
    cyc();
    check("lock_mem0", mem[9'h100], 32'hA000_0000);
    check("lock_mem7", mem[9'h107], 32'hA000_0007);
    check("lock_mem9", mem[9'h109], 32'hA000_0009);

    // Interleave CPU writes with debug reads of 0x004
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h004;
    for (int k = 0; k < 4; k++) begin
      cpu_wr = 1; cpu_addr = 9'h004; cpu_wdata = 32'h1111_0000 + 32'(k);
      @(negedge clk);
      check($sformatf("il_wstall_%0d", k), cpu_stall, 0);
      check($sformatf("il_wgnt_%0d", k), dbg_gnt, 0);
      check($sformatf("il_wr_%0d", k), mem_wr, 1);
      if (k > 0) begin
        check($sformatf("il_rvalid_%0d", k), dbg_rvalid, 1);
        check($sformatf("il_rdata_%0d", k), dbg_rdata, 32'h1111_0000 + 32'(k - 1));
      end
      cyc();
      cpu_wr = 0;
      @(negedge clk);
      check($sformatf("il_rgnt_%0d", k), dbg_gnt, 1);
      check($sformatf("il_rstall_%0d", k), cpu_stall, 0);
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    check("il_rvalid_last", dbg_rvalid, 1);
    check("il_rdata_last", dbg_rdata, 32'h1111_0003);
    cyc();

    // Reset in the middle of a locked burst
    dbg_req = 1; dbg_lock = 1; dbg_we = 1;
    dbg_addr = 9'h180;
    @(negedge clk);
    check("rl_gnt1", dbg_gnt, 1);
    cyc();
    dbg_addr = 9'h181;
    @(negedge clk);
    check("rl_gnt2", dbg_gnt, 1);
    cyc();
    dbg_we = 0; dbg_addr = 9'h010;
    @(negedge clk);
    check("rl_gnt3", dbg_gnt, 1);
    cyc();
    reset = 1;
    @(negedge clk);
    check("rl_rst_gnt", dbg_gnt, 0);
    check("rl_rst_rvalid", dbg_rvalid, 0);
    check("rl_rst_rd", mem_rd, 0);
    cyc();
    reset = 0; dbg_lock = 0;
    @(negedge clk);
    check("rl_post_gnt", dbg_gnt, 1);
    check("rl_post_rvalid", dbg_rvalid, 0);
    cyc();
    dbg_req = 0;
    @(negedge clk);
    check("rl_post_rdata", dbg_rdata, 32'hDEAD_BEEF);
    cyc();

    // Request drop in the cycle the counter saturates
    cpu_rd = 1; cpu_addr = 9'h030; dbg_req = 1; dbg_we = 0; dbg_addr = 9'h010;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("drop_pre_%0d", i), dbg_gnt, 0);
      cyc();
    end
    dbg_req = 0;
    @(negedge clk);
    check("drop_gnt", dbg_gnt, 0);
    check("drop_stall", cpu_stall, 0);
    cyc();
    dbg_req = 1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check($sformatf("drop_post_%0d", i), dbg_gnt, (i == 9) ? 1 : 0);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the pipeline MEM stage and an external debug/loader master. The pipeline has priority. A starvation counter guarantees the debug master eventually wins, and a lock mode gives it bounded bursts. The block sits between the EX/MEM register outputs and `datamemory`, and drives a stall request back to the pipeline hazard logic.

## Interface
Parameters:
- `DM_ADDRESS`, 9, data-memory address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 8, maximum consecutive denied debug cycles, and maximum locked-burst length; must be ≥1

Ports:
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `cpu_rd` in 1: MEM-stage read
- `cpu_wr` in 1: MEM-stage write
- `cpu_addr` in DM_ADDRESS: MEM-stage address
- `cpu_wdata` in DATA_W: MEM-stage write data
- `cpu_funct3` in 3: access size/sign
- `cpu_stall` out 1: MEM-stage access not performed this cycle; hold EX/MEM
- `cpu_rdata` out DATA_W: read data for the CPU
- `dbg_req` in 1: debug access request
- `dbg_we` in 1: 1 = write, 0 = read
- `dbg_lock` in 1: request a locked burst
- `dbg_addr` in DM_ADDRESS: debug address
- `dbg_wdata` in DATA_W: debug write data
- `dbg_gnt` out 1: debug access performed this cycle
- `dbg_rvalid` out 1: debug read data valid
- `dbg_rdata` out DATA_W: debug read data
- `mem_rd` out 1: memory read enable
- `mem_wr` out 1: memory write enable
- `mem_addr` out DM_ADDRESS: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_funct3` out 3: memory access size
- `mem_rdata` in DATA_W: memory read data, valid the cycle after `mem_rd`

## Operation
- `cpu_act = cpu_rd | cpu_wr`.
- States: `S_ARB`, `S_LOCK`, `S_YIELD`. Reset state is `S_ARB`.
- **S_ARB:**
  - `dbg_gnt = dbg_req & (!cpu_act | starve_cnt == STARVE_MAX)`.
  - If `dbg_gnt & dbg_lock`: next state `S_LOCK`, `lock_cnt = 1`.
- **S_LOCK:**
  - `dbg_gnt = dbg_req & dbg_lock`.
  - If granted, `lock_cnt` increments; when `lock_cnt` would reach `STARVE_MAX`, next state is `S_YIELD`.
  - If not granted, next state is `S_ARB`; that cycle the CPU is served normally.
- **S_YIELD:** `dbg_gnt = 0`; the CPU is served; next state is `S_ARB`.
- `cpu_stall = cpu_act & dbg_gnt`.
- **Memory mux:**
  - On `dbg_gnt`: `mem_rd = !dbg_we`, `mem_wr = dbg_we`, `mem_addr = dbg_addr`, `mem_wdata = dbg_wdata`, `mem_funct3 = 3'b010` (word).
  - Otherwise the CPU signals pass through unchanged.
- **starve_cnt:**
  - Increments, saturating at `STARVE_MAX`, on each cycle with `dbg_req & !dbg_gnt` in any state.
  - Clears on `dbg_gnt` or when `dbg_req` = 0.
- **Read return:**
  - Registered `rd_owner_q` (2 bits: valid, debug) captures who issued each `mem_rd`.
  - `dbg_rvalid = rd_owner_q` debug-valid.
  - `dbg_rdata = mem_rdata` when `dbg_rvalid`, else 0.
  - `cpu_rdata = mem_rdata` always (the pipeline only samples it for its own reads).
- Counter widths are `$clog2(STARVE_MAX+1)`; no wrap, saturate only.
- **Simultaneous events:** `dbg_req` deasserting in the same cycle the counter reaches `STARVE_MAX` clears the counter; no grant is issued.

## Timing
- **Reset** (in effect during the reset cycle and after):
  - State `S_ARB`, `starve_cnt = 0`, `lock_cnt = 0`, `rd_owner_q = 0`.
  - `dbg_gnt`, `cpu_stall`, `dbg_rvalid`, `mem_rd`, `mem_wr` forced to 0.
  - `dbg_rdata` = 0.
- **Combinational outputs** (same-cycle): `dbg_gnt`, `cpu_stall`, and all `mem_*` signals.
- **Read latency:** `dbg_rvalid` asserts exactly 1 cycle after a granted debug read. Write latency is 0 (write commits at the grant edge).
- **Stall bounds:**
  - A continuously requesting debug master waits at most `STARVE_MAX` cycles for a grant.
  - A locked burst lasts at most `STARVE_MAX` grants, followed by ≥1 yield cycle.
- **Reset mid-burst:** returns to `S_ARB`; any pending `dbg_rvalid` is dropped.

## Structure
- Add `arb_state_e` (`S_ARB`, `S_LOCK`, `S_YIELD`) and the localparam `DBG_FUNCT3 = 3'b010` to `Pipe_Buf_Reg_PKG`.
- One sub-module: `sat_counter` (parameterized width and max; inc/clr inputs, saturating). It is instantiated twice, for `starve_cnt` and `lock_cnt`.

## Test plan
- **Idle CPU:** `dbg_req = 1`, `dbg_we = 0`, `dbg_addr = 0x010`, memory holds `0xDEADBEEF` → same-cycle `dbg_gnt`, `cpu_stall = 0`; next cycle `dbg_rvalid = 1`, `dbg_rdata = 0xDEADBEEF`.
- **Starvation:** `cpu_rd` held high with `dbg_req` held high, `STARVE_MAX = 8` → `dbg_gnt` first asserts on the 9th cycle, with `cpu_stall = 1` that cycle only.
- **Locked write burst:** `dbg_lock = 1` with CPU idle, 10 back-to-back writes → 8 consecutive grants, 1 yield cycle with `dbg_gnt = 0`, then grants resume.
- **Interleave:** alternate CPU writes and debug reads to address `0x004` → no lost writes; every `dbg_rvalid` carries the last written value; `cpu_stall` is never asserted while `starve_cnt < 8`.
- **Reset mid-lock:** after 3 locked grants, assert `reset` for 1 cycle → `dbg_gnt = 0`, `dbg_rvalid = 0`, state returns to `S_ARB`; the next `dbg_req` with CPU idle is granted immediately.
- **Request drop:** `dbg_req` deasserts in the cycle the counter saturates → no grant, counter reads 0 on the next cycle.
